cp0_timer_ctrl: RTL and testbench

- CP0 timer controller. Owns the Count and Compare registers, the Count prescaler, mtc0/mfc0 access sequencing and timer-interrupt generation.
- Sits beside the CP0 register file. The MEM/WB-stage mtc0 path writes it. mfc0 reads its mux. The exception unit consumes timer_irq and returns irq_ack when it takes the interrupt.

---
 rtl/cp0_timer_pkg.sv | 8 +
 rtl/cp0_tick_div.sv | 19 +
 rtl/cp0_timer_ctrl.sv | 54 +++++
 tb/tb_cp0_timer_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cp0_timer_pkg.sv
// cp0_timer_pkg: shared state encoding, register selects and reset defaults for the CP0 timer.
package cp0_timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, MASKED = 2'd2} state_t;
  localparam logic [1:0] SEL_COUNT = 2'd0;
  localparam logic [1:0] SEL_COMPARE = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [31:0] CMP_RST_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/cp0_tick_div.sv
// cp0_tick_div: Count prescaler, one tick every CNT_DIV unfrozen cycles; clr restarts the period.
module cp0_tick_div #(
  parameter int CNT_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CNT_DIV) + 1;
  localparam logic [W-1:0] LAST = W'(CNT_DIV - 1);
  logic [W-1:0] div_cnt;
  assign tick = (div_cnt == LAST) && !freeze;
  always_ff @(posedge clk) begin
    if (reset || clr) div_cnt <= '0;
    else if (!freeze) div_cnt <= tick ? '0 : div_cnt + W'(1);
  end
endmodule

// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: CP0 Count/Compare registers, mtc0/mfc0 access and timer interrupt FSM.
module cp0_timer_ctrl
  import cp0_timer_pkg::*;
#(
  parameter int CNT_DIV = 2,
  parameter logic [31:0] CMP_RST = CMP_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq,
  input  logic        irq_ack
);
  state_t state, state_n;
  logic tick, wr_count, wr_cmp, match;
  assign wr_count = wr_en && wr_sel == SEL_COUNT;
  assign wr_cmp = wr_en && wr_sel == SEL_COMPARE;
  // a write in the tick cycle (either register) cancels that tick's match
  assign match = tick && !wr_count && !wr_cmp && (count + 32'd1 == compare);
  cp0_tick_div #(.CNT_DIV(CNT_DIV)) u_div (
    .clk(clk), .reset(reset), .freeze(freeze), .clr(wr_count), .tick(tick)
  );
  always_comb begin
    state_n = wr_cmp ? IDLE :
              (state == IDLE && match) ? PENDING :
              (state == PENDING && irq_ack) ? MASKED : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      compare <= CMP_RST;
      state <= IDLE;
      timer_irq <= 1'b0;
    end else begin
      if (wr_count) count <= wr_data;
      else if (tick) count <= count + 32'd1;
      if (wr_cmp) compare <= wr_data;
      state <= state_n;
      timer_irq <= state_n == PENDING;
    end
  end
  always_comb begin
    rd_data = rd_sel == SEL_COUNT ? count :
              rd_sel == SEL_COMPARE ? compare :
              rd_sel == SEL_STATUS ? {29'b0, freeze, state} : 32'd0;
  end
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb_cp0_timer_ctrl: directed vector table plus hand sequences for the CP0 timer controller.
module tb_cp0_timer_ctrl;
  logic clk = 0, reset = 1, freeze = 0, wr_en = 0, irq_ack = 0, timer_irq;
  logic [1:0] wr_sel = 0, rd_sel = 0;
  logic [31:0] wr_data = 0, rd_data, count, compare;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst, we;
    logic [1:0] ws;
    logic [31:0] wd;
    logic ack, frz;
    logic [1:0] rs;
    logic [31:0] ec;
    logic ei;
    logic [31:0] er;
  } vec_t;
  vec_t vq[$];
  cp0_timer_ctrl #(.CNT_DIV(2)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .rd_sel(rd_sel), .rd_data(rd_data), .count(count),
    .compare(compare), .timer_irq(timer_irq), .irq_ack(irq_ack)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, act, exp);
    end
  endtask
  task automatic add(input logic rst, input logic we, input logic [1:0] ws, input logic [31:0] wd,
                     input logic ack, input logic frz, input logic [1:0] rs,
                     input logic [31:0] ec, input logic ei, input logic [31:0] er);
    vq.push_back('{rst, we, ws, wd, ack, frz, rs, ec, ei, er});
  endtask
  task automatic idle(input logic [1:0] rs, input logic [31:0] ec, input logic ei, input logic [31:0] er);
    add(0, 0, 0, 0, 0, 0, rs, ec, ei, er);
  endtask
  task automatic wr(input logic [1:0] ws, input logic [31:0] wd, input logic [1:0] rs,
                    input logic [31:0] ec, input logic ei, input logic [31:0] er);
    add(0, 1, ws, wd, 0, 0, rs, ec, ei, er);
  endtask
  initial begin
    bit seen;
    for (int i = 1; i <= 10; i++) idle(0, i / 2, 0, i / 2);
    wr(1, 8, 1, 5, 0, 8);
    wr(0, 5, 0, 5, 0, 5);
    for (int i = 1; i <= 6; i++) idle(0, 5 + i / 2, i == 6, 5 + i / 2);
    idle(0, 8, 1, 8);
    idle(0, 9, 1, 9);
    add(0, 0, 0, 0, 1, 0, 2, 9, 0, 2);
    wr(0, 7, 2, 7, 0, 2);
    idle(0, 7, 0, 7);
    idle(2, 8, 0, 2);
    wr(1, 20, 2, 8, 0, 0);
    wr(0, 18, 0, 18, 0, 18);
    idle(0, 18, 0, 18);
    idle(0, 19, 0, 19);
    idle(0, 19, 0, 19);
    idle(2, 20, 1, 1);
    wr(0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE);
    wr(1, 0, 1, 32'hFFFF_FFFE, 0, 0);
    idle(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    idle(0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    idle(0, 0, 1, 0);
    wr(1, 10, 1, 0, 0, 10);
    wr(0, 9, 0, 9, 0, 9);
    idle(0, 9, 0, 9);
    wr(1, 10, 0, 10, 0, 10);
    idle(0, 10, 0, 10);
    idle(0, 11, 0, 11);
    wr(0, 10, 0, 10, 0, 10);
    idle(0, 10, 0, 10);
    idle(0, 11, 0, 11);
    idle(0, 11, 0, 11);
    wr(0, 100, 0, 100, 0, 100);
    idle(0, 100, 0, 100);
    idle(0, 101, 0, 101);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 1, 2, 101, 0, 4);
    idle(0, 101, 0, 101);
    idle(0, 102, 0, 102);
    wr(1, 104, 1, 102, 0, 104);
    idle(0, 103, 0, 103);
    idle(0, 103, 0, 103);
    idle(2, 104, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    wr(2, 5, 1, 0, 0, 32'hFFFF_FFFF);
    wr(3, 7, 3, 1, 0, 0);
    step();
    step();
    rd_sel = 2;
    #1;
    chk("rst_count", -1, count, 0);
    chk("rst_compare", -1, compare, 32'hFFFF_FFFF);
    chk("rst_irq", -1, {31'b0, timer_irq}, 0);
    chk("rst_status", -1, rd_data, 0);
    reset = 0;
    foreach (vq[i]) begin
      reset = vq[i].rst; wr_en = vq[i].we; wr_sel = vq[i].ws; wr_data = vq[i].wd;
      irq_ack = vq[i].ack; freeze = vq[i].frz; rd_sel = vq[i].rs;
      step();
      chk("count", i + 1, count, vq[i].ec);
      chk("irq", i + 1, {31'b0, timer_irq}, {31'b0, vq[i].ei});
      chk("rd_data", i + 1, rd_data, vq[i].er);
    end
    reset = 0; wr_en = 1; wr_sel = 1; wr_data = 5; irq_ack = 0; freeze = 0; rd_sel = 0;
    step();
    wr_en = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (timer_irq) seen = 1;
      else step();
    end
    chk("irq_wait", -1, {31'b0, seen}, 1);
    chk("irq_count", -1, count, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
